// File: rtl/uaz_pkg.sv
// ============================================================================
// Module      : uaz_pkg
// Description : Shared datapath definitions for the register file, operand
//               muxes and decoder: default widths, register count, the
//               hard-wired zero register index and the register address type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uaz_pkg;

   localparam int          ADDR_W = 3;
   localparam int          DATA_W = 8;
   localparam int          NREG   = 2 ** ADDR_W;
   localparam int unsigned R_ZERO = 0;

   typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_rz_if.sv
// ============================================================================
// Module      : reg_file_rz_if
// Description : Register file access bundle: two read ports (RX/DX, RY/DY),
//               write-back port (WE/RZ/DZ), issue notification
//               (ISSUE/ISSUE_RZ) and hazard status (BUSY_X/BUSY_Y/STALL/ERR).
//               master = datapath/control side, slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_rz_if #(
   parameter int ADDR_W = uaz_pkg::ADDR_W,
   parameter int DATA_W = uaz_pkg::DATA_W
);

   logic [ADDR_W-1:0] RX;
   logic [ADDR_W-1:0] RY;
   logic [DATA_W-1:0] DX;
   logic [DATA_W-1:0] DY;
   logic              WE;
   logic [ADDR_W-1:0] RZ;
   logic [DATA_W-1:0] DZ;
   logic              ISSUE;
   logic [ADDR_W-1:0] ISSUE_RZ;
   logic              BUSY_X;
   logic              BUSY_Y;
   logic              STALL;
   logic              ERR;

   modport master (
      output RX, RY, WE, RZ, DZ, ISSUE, ISSUE_RZ,
      input  DX, DY, BUSY_X, BUSY_Y, STALL, ERR
   );

   modport slave (
      input  RX, RY, WE, RZ, DZ, ISSUE, ISSUE_RZ,
      output DX, DY, BUSY_X, BUSY_Y, STALL, ERR
   );

endinterface

`default_nettype wire

// File: rtl/rz_scoreboard.sv
// ============================================================================
// Module      : rz_scoreboard
// Description : Write-back scoreboard. Tracks one pending bit per register
//               (bit 0 permanently clear), reports read-after-write hazards
//               on both read ports and flags write-backs to registers that
//               had no pending producer (sticky error).
// Ports       : clk, rst (async, active high)
//               issue, issue_rz  - destination of newly issued instruction
//               we, rz           - write-back strobe / destination
//               rx, ry           - read addresses to test for hazards
//               busy_x, busy_y   - hazard outputs, err - sticky error
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rz_scoreboard
   import uaz_pkg::R_ZERO;
#(
   parameter int ADDR_W = uaz_pkg::ADDR_W
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              issue,
   input  wire logic [ADDR_W-1:0] issue_rz,
   input  wire logic              we,
   input  wire logic [ADDR_W-1:0] rz,
   input  wire logic [ADDR_W-1:0] rx,
   input  wire logic [ADDR_W-1:0] ry,
   output logic                   busy_x,
   output logic                   busy_y,
   output logic                   err
);

   localparam int                NREG   = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(R_ZERO);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            err_q;
   logic            err_d;
   logic            w_wr_valid;

   assign w_wr_valid = we && (rz != ZERO_A);

   always_comb begin
      busy_d = busy_q;
      err_d  = err_q;
      if (w_wr_valid) begin
         busy_d[rz] = 1'b0;
         if (!busy_q[rz]) begin
            err_d = 1'b1;
         end
      end
      // Applied after the clear so a same-cycle issue to the written
      // register leaves the new producer pending.
      if (issue && (issue_rz != ZERO_A)) begin
         busy_d[issue_rz] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   // A write-back landing this cycle is forwarded, so it already resolves
   // the hazard on a matching read port.
   assign busy_x = busy_q[rx] & ~(we && (rz == rx));
   assign busy_y = busy_q[ry] & ~(we && (rz == ry));
   assign err    = err_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_rz.sv
// ============================================================================
// Module      : reg_file_rz
// Description : Eight-entry register bank with hard-wired zero register,
//               two combinational read ports with same-cycle write bypass,
//               one write-back port, and a scoreboard for RAW stalls.
// Ports       : CLK  - system clock
//               RST  - asynchronous active-high reset
//               bus  - reg_file_rz_if.slave (read, write-back, issue, status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_rz
   import uaz_pkg::R_ZERO;
#(
   parameter int DATA_W = uaz_pkg::DATA_W,
   parameter int ADDR_W = uaz_pkg::ADDR_W
) (
   input  wire logic    CLK,
   input  wire logic    RST,
   reg_file_rz_if.slave bus
);

   localparam int                NREG   = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(R_ZERO);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic              w_wr_valid;
   logic              w_byp_x;
   logic              w_byp_y;
   logic              w_busy_x;
   logic              w_busy_y;
   logic              w_err;

   assign w_wr_valid = bus.WE && (bus.RZ != ZERO_A);

   always_comb begin
      regs_d = regs_q;
      if (w_wr_valid) begin
         regs_d[bus.RZ] = bus.DZ;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // R0 is never written, so regs_q[0] stays zero and needs no special read
   // case; the bypass alone must exclude it.
   assign w_byp_x = bus.WE && (bus.RZ == bus.RX) && (bus.RX != ZERO_A);
   assign w_byp_y = bus.WE && (bus.RZ == bus.RY) && (bus.RY != ZERO_A);

   assign bus.DX = w_byp_x ? bus.DZ : regs_q[bus.RX];
   assign bus.DY = w_byp_y ? bus.DZ : regs_q[bus.RY];

   rz_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk      (CLK),
      .rst      (RST),
      .issue    (bus.ISSUE),
      .issue_rz (bus.ISSUE_RZ),
      .we       (bus.WE),
      .rz       (bus.RZ),
      .rx       (bus.RX),
      .ry       (bus.RY),
      .busy_x   (w_busy_x),
      .busy_y   (w_busy_y),
      .err      (w_err)
   );

   assign bus.BUSY_X = w_busy_x;
   assign bus.BUSY_Y = w_busy_y;
   assign bus.STALL  = w_busy_x | w_busy_y;
   assign bus.ERR    = w_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rz.sv
// ============================================================================
// Module      : tb_reg_file_rz
// Description : Self-checking bench for reg_file_rz: directed vector table,
//               hand-written multi-cycle sequences (issue/write collision,
//               sticky error, asynchronous reset) and randomized traffic
//               compared against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_rz;
   import uaz_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_rz_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   reg_file_rz #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: register contents, pending flags, sticky error.
   int m_mem  [NREG];
   bit m_busy [NREG];
   bit m_err;

   typedef struct {
      bit we; int rz; int dz; bit iss; int irz; int rx; int ry;
      int dx; int dy; bit bx; bit by; bit err;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) begin
         m_mem[i]  = 0;
         m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
   endtask

   // What the bank holds after the coming edge, derived from the rules.
   task automatic model_edge();
      int rz;
      int irz;
      rz  = int'(bus.RZ);
      irz = int'(bus.ISSUE_RZ);
      if (bus.WE && rz != 0) begin
         if (!m_busy[rz]) m_err = 1'b1;
         m_mem[rz]  = int'(bus.DZ);
         m_busy[rz] = 1'b0;
      end
      if (bus.ISSUE && irz != 0) m_busy[irz] = 1'b1;
   endtask

   task automatic check_model(input string tag);
      int rx, ry, rz, edx, edy;
      bit ebx, eby;
      rx  = int'(bus.RX);
      ry  = int'(bus.RY);
      rz  = int'(bus.RZ);
      edx = (bus.WE && rz == rx && rx != 0) ? int'(bus.DZ) : m_mem[rx];
      edy = (bus.WE && rz == ry && ry != 0) ? int'(bus.DZ) : m_mem[ry];
      ebx = m_busy[rx] && !(bus.WE && rz == rx);
      eby = m_busy[ry] && !(bus.WE && rz == ry);
      chk({tag, " DX"},     int'(bus.DX),     edx);
      chk({tag, " DY"},     int'(bus.DY),     edy);
      chk({tag, " BUSY_X"}, int'(bus.BUSY_X), int'(ebx));
      chk({tag, " BUSY_Y"}, int'(bus.BUSY_Y), int'(eby));
      chk({tag, " STALL"},  int'(bus.STALL),  int'(ebx | eby));
      chk({tag, " ERR"},    int'(bus.ERR),    int'(m_err));
   endtask

   task automatic drive(input bit we, input int rz, input int dz,
                        input bit iss, input int irz, input int rx, input int ry);
      bus.WE       = we;
      bus.RZ       = AW'(rz);
      bus.DZ       = DW'(dz);
      bus.ISSUE    = iss;
      bus.ISSUE_RZ = AW'(irz);
      bus.RX       = AW'(rx);
      bus.RY       = AW'(ry);
   endtask

   // Advance one cycle; returns 1 ns after the rising edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Directed vectors, one cycle each, checked before the edge.
      //          we rz dz    iss irz rx ry  dx    dy    bx by err
      tbl[0]  = '{0, 0, 0,    0,  0,  0, 7,  0,    0,    0, 0, 0};
      tbl[1]  = '{0, 0, 0,    1,  3,  3, 1,  0,    0,    0, 0, 0};
      tbl[2]  = '{1, 3, 'h5A, 0,  0,  3, 3,  'h5A, 'h5A, 0, 0, 0};
      tbl[3]  = '{0, 0, 0,    0,  0,  3, 0,  'h5A, 0,    0, 0, 0};
      tbl[4]  = '{1, 0, 'hFF, 1,  5,  0, 5,  0,    0,    0, 0, 0};
      tbl[5]  = '{1, 5, 'hC3, 0,  0,  5, 0,  'hC3, 0,    0, 0, 0};
      tbl[6]  = '{0, 0, 0,    1,  2,  5, 2,  'hC3, 0,    0, 0, 0};
      tbl[7]  = '{0, 0, 0,    0,  0,  5, 2,  'hC3, 0,    0, 1, 0};
      tbl[8]  = '{0, 0, 0,    0,  0,  0, 2,  0,    0,    0, 1, 0};
      tbl[9]  = '{1, 2, 'h11, 0,  0,  0, 2,  0,    'h11, 0, 0, 0};
      tbl[10] = '{0, 0, 0,    0,  0,  3, 2,  'h5A, 'h11, 0, 0, 0};

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state on every address.
      for (int a = 0; a < NREG; a++) begin
         drive(0, 0, 0, 0, 0, a, NREG - 1 - a);
         #2;
         chk("reset DX", int'(bus.DX), 0);
         chk("reset DY", int'(bus.DY), 0);
         chk("reset STALL", int'(bus.STALL), 0);
         chk("reset ERR", int'(bus.ERR), 0);
         tick();
      end

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].we, tbl[i].rz, tbl[i].dz, tbl[i].iss, tbl[i].irz, tbl[i].rx, tbl[i].ry);
         #2;
         chk($sformatf("vec%0d DX", i),     int'(bus.DX),     tbl[i].dx);
         chk($sformatf("vec%0d DY", i),     int'(bus.DY),     tbl[i].dy);
         chk($sformatf("vec%0d BUSY_X", i), int'(bus.BUSY_X), int'(tbl[i].bx));
         chk($sformatf("vec%0d BUSY_Y", i), int'(bus.BUSY_Y), int'(tbl[i].by));
         chk($sformatf("vec%0d STALL", i),  int'(bus.STALL),  int'(tbl[i].bx | tbl[i].by));
         chk($sformatf("vec%0d ERR", i),    int'(bus.ERR),    int'(tbl[i].err));
         tick();
      end

      // Issue and write-back to R4 in the same cycle while R4 already pending.
      drive(0, 0, 0, 1, 4, 4, 0);
      #2; chk("r4 issue no comb BUSY_X", int'(bus.BUSY_X), 0);
      tick();
      drive(1, 4, 'h44, 1, 4, 4, 0);
      #2;
      chk("r4 collide DX", int'(bus.DX), 'h44);
      chk("r4 collide BUSY_X", int'(bus.BUSY_X), 0);
      tick();
      drive(0, 0, 0, 0, 0, 4, 0);
      #2;
      chk("r4 after DX", int'(bus.DX), 'h44);
      chk("r4 after BUSY_X", int'(bus.BUSY_X), 1);
      chk("r4 after STALL", int'(bus.STALL), 1);
      chk("r4 after ERR", int'(bus.ERR), 0);
      tick();

      // Write-back to a register with no pending producer: sticky error.
      drive(1, 6, 'h66, 0, 0, 6, 0);
      #2; chk("r6 write ERR same cycle", int'(bus.ERR), 0);
      tick();
      drive(0, 0, 0, 0, 0, 6, 0);
      #2;
      chk("r6 DX", int'(bus.DX), 'h66);
      chk("r6 ERR set", int'(bus.ERR), 1);
      tick();
      drive(1, 4, 'h45, 0, 0, 4, 0);
      #2; chk("r4 clear BUSY_X", int'(bus.BUSY_X), 0);
      tick();
      drive(0, 0, 0, 0, 0, 4, 0);
      #2;
      chk("r4 cleared BUSY_X", int'(bus.BUSY_X), 0);
      chk("ERR sticky", int'(bus.ERR), 1);
      tick();

      // R1 written and still pending, then asynchronous reset mid-cycle.
      drive(0, 0, 0, 1, 1, 0, 0);
      tick();
      drive(1, 1, 'h22, 1, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 1);
      #2;
      chk("r1 DX before reset", int'(bus.DX), 'h22);
      chk("r1 BUSY_X before reset", int'(bus.BUSY_X), 1);
      #1 rst = 1'b1;
      #1;
      chk("async rst DX", int'(bus.DX), 0);
      chk("async rst BUSY_X", int'(bus.BUSY_X), 0);
      chk("async rst STALL", int'(bus.STALL), 0);
      chk("async rst ERR", int'(bus.ERR), 0);
      #2 rst = 1'b0;
      model_clear();
      tick();
      #2;
      chk("post rst DX", int'(bus.DX), 0);
      chk("post rst DY", int'(bus.DY), 0);
      tick();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 31) == 0) begin
            drive($urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, NREG - 1),
                  $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
            rst = 1'b1;
            model_clear();
            #1;
            check_model("rand rst");
            @(posedge clk);
            #1;
            rst = 1'b0;
         end else begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, NREG - 1), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, NREG - 1),
                  $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
            #2;
            check_model("rand");
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
